// File: rtl/team_06_wb_sample_dma.sv
// Multi-channel sample writer: per-channel holding registers, round-robin into a shared FIFO,
// drained as Wishbone single writes into per-channel circular buffers. Optional macro: TEAM06_DMA_TIMEOUT_EN.
module team_06_wb_sample_dma #(
    parameter int          NUM_CH         = 2,
    parameter int          SAMPLE_W       = 16,
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h3300_0000,
    parameter int          BUF_WORDS      = 256,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                         hwclk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [NUM_CH-1:0]            sample_strb,
    input  logic [NUM_CH*SAMPLE_W-1:0]   sample_data,
    input  logic                         clr_status,
    output logic [31:0]                  ADR_O,
    output logic [31:0]                  DAT_O,
    output logic [3:0]                   SEL_O,
    output logic                         WE_O,
    output logic                         STB_O,
    output logic                         CYC_O,
    input  logic [31:0]                  DAT_I,
    input  logic                         ACK_I,
    output logic [NUM_CH-1:0]            ovf,
    output logic [NUM_CH-1:0]            wrap,
    output logic                         busy,
    output logic                         err
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = $clog2(BUF_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = CH_W + SAMPLE_W;

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t                r_state, w_state_next;
    logic [NUM_CH-1:0]     r_hold_vld;
    logic [SAMPLE_W-1:0]   r_hold_data [NUM_CH];
    logic [CH_W-1:0]       r_rr_ptr;
    logic [ENT_W-1:0]      r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic [IDX_W-1:0]      r_wr_idx [NUM_CH];
    logic [CH_W-1:0]       r_cur_ch;
    logic [31:0]           r_adr, r_dat;
    logic [NUM_CH-1:0]     r_ovf, r_wrap;

    logic                  w_push, w_pop, w_ack_done, w_fifo_full, w_to_hit;
    logic [CH_W-1:0]       w_grant;
    logic [CH_W:0]         w_cand;
    logic [NUM_CH-1:0]     w_pushed, w_load, w_ovf_set, w_wr_hit, w_wrap_set;
    logic [ENT_W-1:0]      w_head;
    logic [CH_W-1:0]       w_head_ch;
    logic                  w_unused;

    assign w_unused    = ^{DAT_I, 32'(TIMEOUT_CYCLES)};
    assign w_fifo_full = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_head      = r_fifo_mem[r_rd_ptr];
    assign w_head_ch   = w_head[ENT_W-1 -: CH_W];

    // Round-robin search begins at the channel after the last grant.
    always_comb begin
        w_push  = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cand = (CH_W+1)'(r_rr_ptr) + (CH_W+1)'(i);
            if (w_cand >= (CH_W+1)'(NUM_CH))
                w_cand = w_cand - (CH_W+1)'(NUM_CH);
            if (!w_push && !w_fifo_full && r_hold_vld[w_cand[CH_W-1:0]]) begin
                w_push  = 1'b1;
                w_grant = w_cand[CH_W-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_pushed[gi]   = w_push && (w_grant == CH_W'(gi));
            assign w_load[gi]     = en && sample_strb[gi] && (!r_hold_vld[gi] || w_pushed[gi]);
            assign w_ovf_set[gi]  = en && sample_strb[gi] && r_hold_vld[gi] && !w_pushed[gi];
            assign w_wr_hit[gi]   = w_ack_done && (r_cur_ch == CH_W'(gi));
            assign w_wrap_set[gi] = w_wr_hit[gi] && (r_wr_idx[gi] == '1);
        end
    endgenerate

`ifdef TEAM06_DMA_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge hwclk) begin
        if (reset || r_state != ST_REQ)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    // A timeout in the same cycle as clr_status leaves err set.
    always_ff @(posedge hwclk) begin
        if (reset)
            r_err <= 1'b0;
        else if (r_state == ST_REQ && !ACK_I && w_to_hit)
            r_err <= 1'b1;
        else if (clr_status)
            r_err <= 1'b0;
    end
    assign err = r_err;
`else
    assign w_to_hit = 1'b0;
    assign err      = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_ack_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ACK_I) begin
                    w_ack_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_to_hit) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_hold_vld <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_cur_ch   <= '0;
            r_adr      <= '0;
            r_dat      <= '0;
            r_ovf      <= '0;
            r_wrap     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_hold_data[c] <= '0;
                r_wr_idx[c]    <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_wrap  <= w_wrap_set;
            r_ovf   <= (clr_status ? '0 : r_ovf) | w_ovf_set;
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_cur_ch <= w_head_ch;
                r_dat    <= 32'(w_head[SAMPLE_W-1:0]);
                r_adr    <= BASE_ADDR + ((32'(w_head_ch) * 32'(BUF_WORDS)
                                          + 32'(r_wr_idx[w_head_ch])) << 2);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_load[c]) begin
                    r_hold_vld[c]  <= 1'b1;
                    r_hold_data[c] <= sample_data[c*SAMPLE_W +: SAMPLE_W];
                end else if (w_pushed[c]) begin
                    r_hold_vld[c] <= 1'b0;
                end
                if (w_wr_hit[c])
                    r_wr_idx[c] <= r_wr_idx[c] + 1'b1;
            end
        end
    end

    // FIFO storage has no reset; the pointers alone define its contents.
    always_ff @(posedge hwclk) begin
        if (w_push)
            r_fifo_mem[r_wr_ptr] <= {w_grant, r_hold_data[w_grant]};
    end

    assign ADR_O = r_adr;
    assign DAT_O = r_dat;
    assign SEL_O = 4'hF;
    assign STB_O = (r_state == ST_REQ);
    assign CYC_O = (r_state == ST_REQ);
    assign WE_O  = (r_state == ST_REQ);
    assign ovf   = r_ovf;
    assign wrap  = r_wrap;
    assign busy  = (|r_hold_vld) || (r_count != '0) || (r_state != ST_IDLE);
endmodule

// File: tb/tb_team_06_wb_sample_dma.sv
// Self-checking bench for team_06_wb_sample_dma: directed scenarios plus randomized traffic
// checked against per-channel expected-sample queues and a write-index model.
module tb_team_06_wb_sample_dma;
    localparam int          NCH  = 2;
    localparam int          BUFW = 4;
    localparam logic [31:0] BASE = 32'h3300_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1, en = 1'b1, clr = 1'b0, ack = 1'b0;
    logic [1:0]  strb = '0;
    logic [31:0] sdata = '0, dat_i = '0;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we, stb, cyc, busy, err;
    logic [1:0]  ovf, wrap;

    int checks = 0, failures = 0;
    logic [15:0] q0[$], q1[$];
    int idx_m[NCH];
    int wrap_cnt[NCH];
    int log_ch[$], log_off[$];
    bit ack_hold = 1'b0;
    int ack_delay = 0;

    team_06_wb_sample_dma #(
        .NUM_CH(NCH), .SAMPLE_W(16), .FIFO_DEPTH(4), .BASE_ADDR(BASE),
        .BUF_WORDS(BUFW), .TIMEOUT_CYCLES(10)
    ) dut (
        .hwclk(clk), .reset(reset), .en(en), .sample_strb(strb), .sample_data(sdata),
        .clr_status(clr), .ADR_O(adr), .DAT_O(dat), .SEL_O(sel), .WE_O(we),
        .STB_O(stb), .CYC_O(cyc), .DAT_I(dat_i), .ACK_I(ack),
        .ovf(ovf), .wrap(wrap), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        q0.delete(); q1.delete(); log_ch.delete(); log_off.delete();
        for (int c = 0; c < NCH; c++) begin
            idx_m[c] = 0;
            wrap_cnt[c] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        clear_model();
        reset = 1'b0;
        tick();
    endtask

    task automatic strobe(input logic [1:0] mask, input logic [15:0] d0, input logic [15:0] d1, input bit keep);
        strb  = mask;
        sdata = {d1, d0};
        if (keep && en) begin
            if (mask[0]) q0.push_back(d0);
            if (mask[1]) q1.push_back(d1);
        end
        tick();
        strb = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || stb) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_within_budget", 32'(n < budget), 32'd1);
        tick();
    endtask

    // Bus monitor and ACK responder: a write completes at the edge following a negedge where STB and ACK were both high.
    initial begin
        logic        p_stb, p_ack;
        logic [31:0] p_adr, p_dat;
        logic [1:0]  exp_wrap;
        int          wait_cnt, off, ch;
        logic [15:0] expd;
        p_stb = 0; p_ack = 0; p_adr = 0; p_dat = 0; wait_cnt = 0;
        forever begin
            @(negedge clk);
            exp_wrap = '0;
            if (p_stb && p_ack) begin
                off = int'((p_adr - BASE) >> 2);
                ch  = off / BUFW;
                chk("write_channel_in_range", 32'(ch < NCH), 32'd1);
                if (ch < NCH) begin
                    chk("write_addr", p_adr, BASE + 32'((ch * BUFW + idx_m[ch]) * 4));
                    chk("write_expected", 32'(ch == 0 ? q0.size() > 0 : q1.size() > 0), 32'd1);
                    if (ch == 0 && q0.size() > 0) expd = q0.pop_front();
                    else if (ch == 1 && q1.size() > 0) expd = q1.pop_front();
                    else expd = 16'h0;
                    chk("write_data", p_dat, {16'h0, expd});
                    log_ch.push_back(ch);
                    log_off.push_back(ch * BUFW + idx_m[ch]);
                    idx_m[ch] = (idx_m[ch] + 1) % BUFW;
                    if (idx_m[ch] == 0) begin
                        exp_wrap[ch] = 1'b1;
                        wrap_cnt[ch]++;
                    end
                end
                chk("stb_low_after_ack", 32'(stb), 32'd0);
            end
            chk("wrap_pulse", 32'(wrap), 32'(exp_wrap));
            if (stb) begin
                chk("sel_o", 32'(sel), 32'hF);
                chk("we_cyc", 32'({we, cyc}), 32'h3);
            end
            if (reset) begin
                ack = 1'b0;
                wait_cnt = 0;
            end else if (stb && !ack_hold && !ack) begin
                if (wait_cnt >= ack_delay) ack = 1'b1;
                else wait_cnt++;
            end else begin
                ack = 1'b0;
                wait_cnt = 0;
            end
            p_stb = stb && !reset;
            p_ack = ack;
            p_adr = adr;
            p_dat = dat;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_ch[6]  = '{0, 1, 0, 1, 0, 1};
        int rr_off[6] = '{0, 4, 1, 5, 2, 6};
        int wr_off[5] = '{0, 1, 2, 3, 0};
        int last_strb[NCH];
        logic [1:0] m;

        // Reset values
        tick(); tick();
        chk("rst_stb_cyc_we", 32'({stb, cyc, we}), 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_dat", dat, 32'd0);
        chk("rst_flags", 32'({ovf, wrap, busy, err}), 32'd0);
        clear_model();
        reset = 1'b0;
        tick();

        // Single sample: latency of three edges to STB
        strobe(2'b10, 16'h0000, 16'hBEEF, 1'b1);
        tick();
        chk("single_stb_not_early", 32'(stb), 32'd0);
        tick();
        chk("single_stb_rise", 32'(stb), 32'd1);
        chk("single_adr", adr, BASE + 32'(BUFW * 4));
        chk("single_dat", dat, 32'h0000_BEEF);
        chk("single_sel_we", 32'({sel, we}), 32'h1F);
        wait_idle(50);

        // Round-robin alternation
        do_reset();
        for (int k = 0; k < 3; k++) begin
            strobe(2'b11, 16'($urandom), 16'($urandom), 1'b1);
            tick(); tick(); tick();
        end
        wait_idle(100);
        chk("rr_count", 32'(log_ch.size()), 32'd6);
        for (int k = 0; k < 6 && k < log_ch.size(); k++) begin
            chk("rr_channel", 32'(log_ch[k]), 32'(rr_ch[k]));
            chk("rr_offset", 32'(log_off[k]), 32'(rr_off[k]));
        end
        chk("rr_no_ovf", 32'(ovf), 32'd0);

        // Wrap of the channel 0 index
        do_reset();
        for (int k = 0; k < 5; k++) begin
            strobe(2'b01, 16'($urandom), 16'h0, 1'b1);
            tick(); tick();
        end
        wait_idle(100);
        chk("wrap_count_ch0", 32'(wrap_cnt[0]), 32'd1);
        for (int k = 0; k < 5 && k < log_off.size(); k++)
            chk("wrap_offset", 32'(log_off[k]), 32'(wr_off[k]));

        // Overflow with the bus stalled
        do_reset();
        ack_hold = 1'b1;
        for (int k = 0; k < 6; k++) begin
            strobe(2'b01, 16'(16'h1000 + k), 16'h0, 1'b1);
            tick(); tick();
        end
        chk("ovf_not_yet", 32'(ovf), 32'd0);
        strobe(2'b01, 16'hDEAD, 16'h0, 1'b0);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        clr = 1'b1;
        strobe(2'b01, 16'hDEAD, 16'h0, 1'b0);
        clr = 1'b0;
        chk("ovf_set_wins_clr", 32'(ovf), 32'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        ack_hold = 1'b0;
        wait_idle(200);
        chk("ovf_all_kept_written", 32'(q0.size()), 32'd0);
        chk("ovf_written_count", 32'(log_ch.size()), 32'd6);

        // Reset while STB is high
        ack_hold = 1'b1;
        strobe(2'b10, 16'h0, 16'h5A5A, 1'b1);
        tick(); tick(); tick();
        chk("midrst_stb_high", 32'(stb), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_stb_cyc", 32'({stb, cyc}), 32'd0);
        chk("midrst_adr_dat", adr | dat, 32'd0);
        chk("midrst_flags", 32'({ovf, wrap, busy, err}), 32'd0);
        clear_model();
        ack_hold = 1'b0;
        reset = 1'b0;
        tick();
        strobe(2'b10, 16'h0, 16'h1234, 1'b1);
        wait_idle(50);
        chk("midrst_idx_restart", 32'(log_off.size() > 0 ? log_off[log_off.size()-1] : -1), 32'(BUFW));

        // en low: strobes ignored
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            strobe(2'b11, 16'($urandom), 16'($urandom), 1'b1);
            tick();
        end
        repeat (10) tick();
        chk("en_low_idle", 32'(busy), 32'd0);
        chk("en_low_no_writes", 32'(log_ch.size()), 32'd1);
        en = 1'b1;
        ack_delay = 3;
        strobe(2'b01, 16'h7777, 16'h0, 1'b1);
        tick(); tick(); tick();
        en = 1'b0;
        wait_idle(50);
        chk("en_low_inflight_done", 32'(q0.size()), 32'd0);
        en = 1'b1;
        ack_delay = 0;

        // Randomized traffic, spaced so no channel can overflow
        do_reset();
        for (int c = 0; c < NCH; c++) last_strb[c] = 100;
        for (int cyc_i = 0; cyc_i < 600; cyc_i++) begin
            ack_delay = $urandom_range(0, 2);
            m = '0;
            for (int c = 0; c < NCH; c++) begin
                last_strb[c]++;
                if (last_strb[c] >= 12 && $urandom_range(0, 3) == 0) begin
                    m[c] = 1'b1;
                    last_strb[c] = 0;
                end
            end
            strobe(m, 16'($urandom), 16'($urandom), 1'b1);
        end
        wait_idle(200);
        chk("rand_q0_drained", 32'(q0.size()), 32'd0);
        chk("rand_q1_drained", 32'(q1.size()), 32'd0);
        chk("rand_no_ovf", 32'(ovf), 32'd0);
        ack_delay = 0;

`ifdef TEAM06_DMA_TIMEOUT_EN
        // ACK never arrives: STB held for exactly the timeout window
        do_reset();
        begin
            int hi = 0, n = 0;
            ack_hold = 1'b1;
            strobe(2'b01, 16'hCAFE, 16'h0, 1'b1);
            while (!stb && n < 10) begin tick(); n++; end
            while (stb && hi < 30) begin tick(); hi++; end
            chk("timeout_stb_cycles", 32'(hi), 32'd10);
            chk("timeout_err", 32'(err), 32'd1);
            void'(q0.pop_front());
            ack_hold = 1'b0;
            strobe(2'b01, 16'hF00D, 16'h0, 1'b1);
            wait_idle(50);
            chk("timeout_same_addr", 32'(log_off.size() > 0 ? log_off[0] : -1), 32'd0);
            clr = 1'b1; tick(); clr = 1'b0;
            chk("timeout_err_cleared", 32'(err), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/team_06_wb_sample_dma.md
# team_06_wb_sample_dma

Parametrised multi-channel sample writer for the team_06 audio datapath. It captures single-cycle sample strobes from up to NUM_CH sources such as the ADC deserialiser and I2S receivers, and arbitrates them round-robin into a shared FIFO. It drains the FIFO as Wishbone single-write cycles into per-channel circular buffers in memory. It generalises the fixed single-master hookup of team_06_top into a configurable channel count, sample width, FIFO depth and buffer size, with overflow and wrap reporting.

## Interface
Parameters:
- NUM_CH, 2: number of sample channels (1..4).
- SAMPLE_W, 16: sample width in bits (8..32). Zero-extended to 32 on the bus.
- FIFO_DEPTH, 8: shared FIFO entries (power of 2, at least 2).
- BASE_ADDR, 32'h3300_0000: byte address of the channel 0 buffer.
- BUF_WORDS, 256: 32-bit words per channel buffer (power of 2).
- TIMEOUT_CYCLES, 255: ACK wait limit. Used only with TEAM06_DMA_TIMEOUT_EN.

Ports:
- hwclk, in, 1: sole clock. All logic is on the rising edge.
- reset, in, 1: synchronous reset, active-high.
- en, in, 1: when low, new strobes are ignored; the FIFO and any in-flight cycle continue to drain.
- sample_strb, in, NUM_CH: one-cycle "sample ready" pulse per channel.
- sample_data, in, NUM_CH*SAMPLE_W: channel c occupies bits [c*SAMPLE_W +: SAMPLE_W].
- clr_status, in, 1: one-cycle pulse that clears ovf and err.
- ADR_O, out, 32: Wishbone address.
- DAT_O, out, 32: Wishbone write data.
- SEL_O, out, 4: byte selects, constant 4'hF.
- WE_O, out, 1: write enable. High whenever CYC_O is high.
- STB_O, out, 1: Wishbone strobe.
- CYC_O, out, 1: Wishbone cycle.
- DAT_I, in, 32: unused; present for bus symmetry.
- ACK_I, in, 1: Wishbone acknowledge.
- ovf, out, NUM_CH: sticky flag, set when a channel's sample is dropped.
- wrap, out, NUM_CH: one-cycle pulse when a channel's write index wraps to 0.
- busy, out, 1: high when any holding register is valid, the FIFO is non-empty, or the bus FSM is not IDLE.
- err, out, 1: sticky ACK-timeout flag. Constant 0 without the macro.

## Operation
- Capture:
  - Each channel has a one-entry holding register.
  - A strobe with en high loads the holding register if it is empty.
  - A strobe while the register is still full drops the new sample, keeps the held one, and sets ovf[c].
- Arbitration:
  - Each cycle, at most one valid holding register is pushed into the FIFO, as the entry {ch, data}.
  - The push happens only if the FIFO is not full.
  - Selection is round-robin, starting from the channel after the last one granted. After reset, channel 0 has priority.
  - A holding register can be refilled by a strobe in the same cycle it is pushed.
- FIFO:
  - Count-based.
  - When full, holding registers wait; a strobe to a still-full holding register then overflows as above.
  - There is no push-on-full, even if a pop occurs in the same cycle.
- Bus FSM: IDLE -> REQ -> IDLE.
  - IDLE, FIFO non-empty: pop the head and register ADR_O/DAT_O. Go to REQ.
  - REQ: STB_O = CYC_O = WE_O = 1, with ADR_O and DAT_O stable.
  - REQ on ACK_I high: increment wr_idx[ch] modulo BUF_WORDS. Pulse wrap[ch] if the new index is 0. Go to IDLE.
- Address:
  - ADR_O = BASE_ADDR + ((ch*BUF_WORDS + wr_idx[ch]) << 2), computed in 32 bits.
  - The wr_idx width is log2(BUF_WORDS).
- Status:
  - clr_status clears ovf and err.
  - A set event in the same cycle as clr_status wins.

## Timing
- Reset values:
  - STB_O, CYC_O and WE_O are 0.
  - ADR_O and DAT_O are 0.
  - ovf, wrap, busy and err are 0.
  - All wr_idx values are 0.
  - The FIFO and holding registers are empty.
  - The FSM is in IDLE.
  - The round-robin pointer selects channel 0.
- Latency:
  - A strobe at cycle N makes the holding register valid at N+1.
  - The entry enters the FIFO at N+2.
  - STB_O rises at N+3 at the earliest.
- Bus cycles:
  - ACK_I sampled high at edge M drops STB_O and CYC_O at M.
  - There is at least one IDLE cycle between transactions, so the best case is 2 cycles per word.
- Reset mid-transfer:
  - STB_O and CYC_O fall at that edge.
  - Queued samples are discarded. wr_idx values return to 0.
- en low mid-transfer does not abort the current cycle.

## Configuration
- TEAM06_DMA_TIMEOUT_EN defined:
  - A counter runs during REQ.
  - If ACK_I has not arrived after TIMEOUT_CYCLES cycles, the FSM drops STB_O/CYC_O, discards the word without advancing wr_idx, sets err, and returns to IDLE.
- TEAM06_DMA_TIMEOUT_EN undefined:
  - REQ waits indefinitely and err is tied to 0.
  - No counter logic is synthesised.

## Test plan
- Single sample:
  - Setup: NUM_CH=2. Strobe ch1 with data 16'hBEEF at cycle 10. ACK one cycle after STB.
  - Expect: STB at cycle 13, ADR_O = BASE_ADDR + 0x400, DAT_O = 32'h0000_BEEF, SEL_O = 4'hF, WE_O = 1.
- Round-robin:
  - Setup: strobe ch0 and ch1 in the same cycle, three times, with an immediate ACK.
  - Expect: writes alternate ch0, ch1, ch0, ch1, ch0, ch1, with ADR word offsets 0, 256, 1, 257, 2, 258.
- Overflow:
  - Setup: hold ACK_I low, fill the FIFO, then strobe ch0 twice more.
  - Expect: the first extra strobe is held and the second sets ovf[0]; no stored data is corrupted.
  - Expect: clr_status clears ovf.
- Wrap:
  - Setup: BUF_WORDS=4. Write 5 samples on ch0.
  - Expect: word offsets 0, 1, 2, 3, 0, and wrap[0] pulses on the 4th ACK.
- Reset and en:
  - Setup: assert reset while STB is high.
  - Expect: STB/CYC fall at that edge and all outputs return to their reset values.
  - Setup: drive en=0 while strobing.
  - Expect: no new writes.
- Timeout (macro on):
  - Setup: TIMEOUT_CYCLES=10 and never ACK.
  - Expect: STB falls after 10 cycles, err goes to 1, and the next sample reuses the same address.
